// File: rtl/key_switch_reader.sv
// Operator-input front end: synchronizes and debounces two pushbuttons and four
// slide switches, then drives a 4-bit operand that can be loaded or stepped.
module key_switch_reader #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_RATE     = 5000000
) (
    input  logic       CLOCK_50,
    input  logic       RESET_N,
    input  logic       KEY_LOAD,
    input  logic       KEY_INC,
    input  logic [3:0] SW,
    output logic [3:0] Q,
    output logic       Q_VALID,
    output logic       INC_HELD
);

    localparam int NUM_IN = 6;
    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    localparam int TMR_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

    // Bit order {KEY_LOAD, KEY_INC, SW[3:0]}; keys come out of reset released.
    localparam logic [NUM_IN-1:0] DB_RESET = 6'b11_0000;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } inc_state_t;

    logic [NUM_IN-1:0] raw;
    logic [NUM_IN-1:0] sync_1;
    logic [NUM_IN-1:0] sync_2;
    logic [NUM_IN-1:0] db;

    logic       load_db;
    logic       inc_db;
    logic [3:0] sw_db;
    logic       load_prev;
    logic       inc_prev;
    logic       load_ev;
    logic       inc_ev;

    inc_state_t       state;
    inc_state_t       state_next;
    logic [TMR_W-1:0] timer;
    logic             inc_step;
    logic             timer_clr;

    assign raw = {KEY_LOAD, KEY_INC, SW};

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync_1 <= '0;
            sync_2 <= '0;
        end else begin
            sync_1 <= raw;
            sync_2 <= sync_1;
        end
    end

    // Each input only follows its synchronized copy after DEBOUNCE_CYCLES
    // consecutive disagreeing samples; any agreement restarts the count.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_debounce
        logic [DB_W-1:0] cnt;
        logic            db_r;

        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                cnt  <= '0;
                db_r <= DB_RESET[i];
            end else if (sync_2[i] == db_r) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                db_r <= sync_2[i];
                cnt  <= '0;
            end else begin
                cnt <= cnt + DB_W'(1);
            end
        end

        assign db[i] = db_r;
    end

    assign {load_db, inc_db, sw_db} = db;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            load_prev <= 1'b1;
            inc_prev  <= 1'b1;
        end else begin
            load_prev <= load_db;
            inc_prev  <= inc_db;
        end
    end

    // Keys are active-low, so a press is a debounced 1 -> 0 edge.
    assign load_ev = load_prev & ~load_db;
    assign inc_ev  = inc_prev & ~inc_db;

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A release seen in the same cycle as a timer expiry wins: no step.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (inc_ev) begin
                    state_next = DELAY;
                end
            end
            DELAY: begin
                if (inc_db) begin
                    state_next = IDLE;
                end else if (timer == DELAY_LAST) begin
                    state_next = REPEAT;
                end
            end
            REPEAT: begin
                if (inc_db) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        inc_step  = 1'b0;
        timer_clr = 1'b0;
        case (state)
            IDLE: begin
                timer_clr = 1'b1;
                inc_step  = inc_ev;
            end
            DELAY: begin
                if (inc_db) begin
                    timer_clr = 1'b1;
                end else if (timer == DELAY_LAST) begin
                    inc_step  = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            REPEAT: begin
                if (inc_db) begin
                    timer_clr = 1'b1;
                end else if (timer == RATE_LAST) begin
                    inc_step  = 1'b1;
                    timer_clr = 1'b1;
                end
            end
            default: timer_clr = 1'b1;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            timer <= '0;
        end else if (timer_clr) begin
            timer <= '0;
        end else begin
            timer <= timer + TMR_W'(1);
        end
    end

    assign INC_HELD = (state != IDLE);

    // Q_VALID is a one-cycle strobe registered together with Q; there is no
    // back-pressure, so every strobe marks exactly one new value on Q.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            Q       <= 4'd0;
            Q_VALID <= 1'b0;
        end else begin
            Q_VALID <= 1'b0;
            if (load_ev) begin
                Q       <= sw_db;
                Q_VALID <= 1'b1;
            end else if (inc_step) begin
                Q       <= Q + 4'd1;
                Q_VALID <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_key_switch_reader.sv
// Bench for key_switch_reader: random and directed key/switch activity scored
// against a reference model of the debounce, load and auto-repeat rules.
module tb_key_switch_reader;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RR = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       key_load = 1'b1;
  logic       key_inc = 1'b1;
  logic [3:0] sw = 4'h0;
  logic [3:0] q;
  logic       q_valid;
  logic       inc_held;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  logic [3:0] exp_q[$];

  // reference model state
  logic [5:0] dly[$];
  logic [5:0] last_seen;
  int         run_len[6];
  logic [5:0] m_db;
  logic [5:0] m_db_last;
  logic [3:0] m_q;
  int         m_held;
  bit         m_valid;

  key_switch_reader #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY(RD),
    .REPEAT_RATE(RR)
  ) dut (
    .CLOCK_50(clk),
    .RESET_N(rst_n),
    .KEY_LOAD(key_load),
    .KEY_INC(key_inc),
    .SW(sw),
    .Q(q),
    .Q_VALID(q_valid),
    .INC_HELD(inc_held)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("reset_q", q, 4'd0);
    check("reset_q_valid", q_valid, 1'b0);
    check("reset_inc_held", inc_held, 1'b0);
    hold(3);
    #2 rst_n = 1'b1;
  endtask

  // reference model: input delayed two samples, a level is accepted once it has
  // been seen D samples in a row, presses step Q at press, press+RD, then every RR
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly.delete();
      dly.push_back(6'h00);
      dly.push_back(6'h00);
      last_seen = 6'b11_0000;
      for (int i = 0; i < 6; i++) run_len[i] = 0;
      m_db      = 6'b11_0000;
      m_db_last = 6'b11_0000;
      m_q       = 4'd0;
      m_held    = -1;
      m_valid   = 1'b0;
      exp_q.delete();
    end else begin
      logic [5:0] seen;
      bit load_ev;
      bit inc_ev;
      bit do_inc;
      seen = dly.pop_front();
      dly.push_back({key_load, key_inc, sw});
      load_ev = m_db_last[5] && !m_db[5];
      inc_ev  = m_db_last[4] && !m_db[4];
      do_inc  = 1'b0;
      if (m_held >= 0 && m_db[4]) begin
        m_held = -1;
      end else if (m_held < 0) begin
        if (inc_ev) begin
          do_inc = 1'b1;
          m_held = 0;
        end
      end else begin
        m_held++;
        if (m_held == RD || (m_held > RD && (m_held - RD) % RR == 0)) do_inc = 1'b1;
      end
      m_valid = 1'b0;
      if (load_ev) begin
        m_q = m_db[3:0];
        m_valid = 1'b1;
      end else if (do_inc) begin
        m_q = m_q + 4'd1;
        m_valid = 1'b1;
      end
      if (m_valid) exp_q.push_back(m_q);
      m_db_last = m_db;
      for (int i = 0; i < 6; i++) begin
        if (seen[i] == last_seen[i]) run_len[i]++;
        else run_len[i] = 1;
        last_seen[i] = seen[i];
        if (run_len[i] >= D && seen[i] != m_db[i]) m_db[i] = seen[i];
      end
    end
  end

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      check("q_valid", q_valid, m_valid);
      if (exp_q.size() > 0 && (q_valid || m_valid)) begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (q_valid) check("q_scoreboard", q, e);
      end else if (q_valid) begin
        total++;
        bad++;
        $display("FAIL q_unexpected: got q=%0h with q_valid=1, required no update", q);
      end
      check("inc_held", inc_held, (m_held >= 0));
      check("q_level", q, m_q);
    end
  end

  initial begin
    sw = 4'hA;
    do_reset();
    mon_en = 1'b1;
    hold(20);
    check("idle_q", q, 4'd0);
    check("idle_inc_held", inc_held, 1'b0);

    // load 9 with a long hold: a single update
    sw = 4'h9;
    hold(8);
    key_load = 1'b0;
    hold(30);
    check("load_9", q, 4'd9);
    key_load = 1'b1;
    hold(12);

    // short increment glitch never propagates
    key_inc = 1'b0;
    hold(3);
    key_inc = 1'b1;
    hold(12);
    check("glitch_q", q, 4'd9);

    // load 14, then hold increment across the wrap
    sw = 4'hE;
    hold(8);
    key_load = 1'b0;
    hold(10);
    key_load = 1'b1;
    hold(10);
    check("load_14", q, 4'd14);
    key_inc = 1'b0;
    hold(40);
    key_inc = 1'b1;
    hold(6);
    check("held_before_drop", inc_held, 1'b1);
    hold(1);
    check("held_after_drop", inc_held, 1'b0);
    check("repeat_end_q", q, 4'd5);
    hold(10);

    // load and increment pressed together: load wins, repeat still runs
    sw = 4'h3;
    hold(8);
    key_load = 1'b0;
    key_inc = 1'b0;
    hold(15);
    key_load = 1'b1;
    key_inc = 1'b1;
    hold(12);
    check("load_inc_same", q, 4'd4);

    // reset while auto-repeating with the key still held
    sw = 4'h5;
    hold(8);
    key_load = 1'b0;
    hold(10);
    key_load = 1'b1;
    hold(10);
    key_inc = 1'b0;
    hold(19);
    check("pre_reset_q", q, 4'd7);
    check("pre_reset_held", inc_held, 1'b1);
    do_reset();
    hold(8);
    check("post_reset_press", q, 4'd1);
    key_inc = 1'b1;
    hold(15);

    // randomized activity
    for (int n = 0; n < 150; n++) begin
      sw = 4'($urandom_range(0, 15));
      key_load = ($urandom_range(0, 3) == 0) ? 1'b0 : 1'b1;
      key_inc = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
      hold($urandom_range(1, 24));
    end

    key_load = 1'b1;
    key_inc = 1'b1;
    hold(30);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
